// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PIC bus-controller types, command-word bit positions and OCW2 encodings
package pic_pkg;

    typedef enum logic [2:0] {
        S_ICW1  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } pic_state_e;

    localparam int unsigned ICW1_IC4  = 0;
    localparam int unsigned ICW1_SNGL = 1;
    localparam int unsigned ICW1_LTIM = 3;
    localparam int unsigned ICW1_SEL  = 4;

    localparam int unsigned OCW_SEL3  = 3;
    localparam int unsigned OCW3_RIS  = 0;
    localparam int unsigned OCW3_RR   = 1;
    localparam int unsigned OCW3_P    = 2;
    localparam int unsigned OCW3_SMM  = 5;
    localparam int unsigned OCW3_ESMM = 6;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_S_EOI        = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_S_EOI    = 3'b111;

    // IRQ0 is highest priority, so the lowest set index wins.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pic_strobe_sync.sv
// rtl/pic_strobe_sync.sv - multi-stage synchroniser for an active-low bus strobe with edge pulses
module pic_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n_i,
    output logic sync_n_o,
    output logic fall_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    // Idle strobe level is high, so the chain resets to ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], strobe_n_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_n_o = chain_q[SYNC_STAGES-1];
    assign fall_o   = prev_q & ~chain_q[SYNC_STAGES-1];
    assign rise_o   = ~prev_q & chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_bus_ctrl.sv
// rtl/pic_bus_ctrl.sv - PIC CPU bus interface, ICW1..ICW4 sequencer and OCW register file
// Optional poll command support is built when PIC_POLL_CMD_EN is defined.
module pic_bus_ctrl
    import pic_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              wr_n,
    input  logic              rd_n,
    input  logic              a0,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              d_oe,
    input  logic [DATA_W-1:0] irr_in,
    input  logic [DATA_W-1:0] isr_in,
    output logic              init_done,
    output logic [4:0]        vec_base,
    output logic              ltim,
    output logic              sngl,
    output logic              ic4,
    output logic [DATA_W-1:0] icw3,
    output logic [4:0]        icw4,
    output logic [DATA_W-1:0] imr,
    output logic              ocw2_vld,
    output logic [2:0]        ocw2_cmd,
    output logic [2:0]        ocw2_lvl,
    output logic              ris,
    output logic              smm
`ifdef PIC_POLL_CMD_EN
    ,
    output logic              poll_ack
`endif
);

    logic wr_sync, wr_fall, wr_rise;
    logic rd_sync, rd_fall, rd_rise;

    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk(clk), .rst_n(rst_n), .strobe_n_i(wr_n),
        .sync_n_o(wr_sync), .fall_o(wr_fall), .rise_o(wr_rise)
    );

    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clk(clk), .rst_n(rst_n), .strobe_n_i(rd_n),
        .sync_n_o(rd_sync), .fall_o(rd_fall), .rise_o(rd_rise)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, wr_fall, rd_fall, rd_rise};

    pic_state_e        state_q, state_d;
    logic              cs_q, a0_q;
    logic [DATA_W-1:0] din_q;
    logic              ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
    logic [4:0]        vec_base_q, vec_base_d, icw4_q, icw4_d;
    logic [DATA_W-1:0] icw3_q, icw3_d, imr_q, imr_d;
    logic              ocw2_vld_q, ocw2_vld_d;
    logic [2:0]        ocw2_cmd_q, ocw2_cmd_d, ocw2_lvl_q, ocw2_lvl_d;
    logic              ris_q, ris_d, smm_q, smm_d;

    // Bus fields are sampled throughout the strobe; the commit uses the last sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q  <= 1'b1;
            a0_q  <= 1'b0;
            din_q <= '0;
        end else if (!wr_sync) begin
            cs_q  <= cs_n;
            a0_q  <= a0;
            din_q <= d_in;
        end
    end

    logic commit, icw1_wr, data_wr, ocw_wr;
    assign commit  = wr_rise & ~cs_q;
    assign icw1_wr = commit & ~a0_q & din_q[ICW1_SEL];
    assign data_wr = commit & a0_q;
    assign ocw_wr  = commit & ~a0_q & ~din_q[ICW1_SEL] & (state_q == S_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_ICW1;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (icw1_wr) begin
            state_d = S_ICW2;
        end else if (data_wr) begin
            case (state_q)
                S_ICW2:  state_d = !sngl_q ? S_ICW3 : (ic4_q ? S_ICW4 : S_READY);
                S_ICW3:  state_d = ic4_q ? S_ICW4 : S_READY;
                S_ICW4:  state_d = S_READY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        init_done = (state_q == S_READY);
    end

`ifdef PIC_POLL_CMD_EN
    logic poll_armed_q, poll_armed_d, poll_ack_q, poll_ack_d;
    logic rd_cs_q, rd_a0_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cs_q <= 1'b1;
            rd_a0_q <= 1'b0;
        end else if (!rd_sync) begin
            rd_cs_q <= cs_n;
            rd_a0_q <= a0;
        end
    end
`endif

    always_comb begin
        ltim_d     = ltim_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        vec_base_d = vec_base_q;
        icw3_d     = icw3_q;
        icw4_d     = icw4_q;
        imr_d      = imr_q;
        ocw2_vld_d = 1'b0;
        ocw2_cmd_d = ocw2_cmd_q;
        ocw2_lvl_d = ocw2_lvl_q;
        ris_d      = ris_q;
        smm_d      = smm_q;
`ifdef PIC_POLL_CMD_EN
        poll_armed_d = poll_armed_q;
        poll_ack_d   = 1'b0;
        if (poll_armed_q && rd_rise && !rd_cs_q && !rd_a0_q) begin
            poll_armed_d = 1'b0;
            poll_ack_d   = 1'b1;
        end
`endif
        if (icw1_wr) begin
            ltim_d = din_q[ICW1_LTIM];
            sngl_d = din_q[ICW1_SNGL];
            ic4_d  = din_q[ICW1_IC4];
            icw3_d = '0;
            icw4_d = '0;
            imr_d  = '0;
            ris_d  = 1'b0;
            smm_d  = 1'b0;
`ifdef PIC_POLL_CMD_EN
            poll_armed_d = 1'b0;
`endif
        end else if (data_wr) begin
            case (state_q)
                S_ICW2:  vec_base_d = din_q[7:3];
                S_ICW3:  icw3_d     = din_q;
                S_ICW4:  icw4_d     = din_q[4:0];
                S_READY: imr_d      = din_q;
                default: ;
            endcase
        end else if (ocw_wr) begin
            if (!din_q[OCW_SEL3]) begin
                ocw2_vld_d = 1'b1;
                ocw2_cmd_d = din_q[7:5];
                ocw2_lvl_d = din_q[2:0];
            end else begin
                if (din_q[OCW3_RR])   ris_d = din_q[OCW3_RIS];
                if (din_q[OCW3_ESMM]) smm_d = din_q[OCW3_SMM];
`ifdef PIC_POLL_CMD_EN
                if (din_q[OCW3_P])    poll_armed_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            vec_base_q <= '0;
            icw3_q     <= '0;
            icw4_q     <= '0;
            imr_q      <= '0;
            ocw2_vld_q <= 1'b0;
            ocw2_cmd_q <= '0;
            ocw2_lvl_q <= '0;
            ris_q      <= 1'b0;
            smm_q      <= 1'b0;
`ifdef PIC_POLL_CMD_EN
            poll_armed_q <= 1'b0;
            poll_ack_q   <= 1'b0;
`endif
        end else begin
            ltim_q     <= ltim_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            vec_base_q <= vec_base_d;
            icw3_q     <= icw3_d;
            icw4_q     <= icw4_d;
            imr_q      <= imr_d;
            ocw2_vld_q <= ocw2_vld_d;
            ocw2_cmd_q <= ocw2_cmd_d;
            ocw2_lvl_q <= ocw2_lvl_d;
            ris_q      <= ris_d;
            smm_q      <= smm_d;
`ifdef PIC_POLL_CMD_EN
            poll_armed_q <= poll_armed_d;
            poll_ack_q   <= poll_ack_d;
`endif
        end
    end

    // A read that overlaps a write never drives the pads.
    logic [DATA_W-1:0] rd_mux;
    always_comb begin
        d_oe   = ~rd_sync & ~cs_n & wr_sync;
        rd_mux = a0 ? imr_q : (ris_q ? isr_in : irr_in);
`ifdef PIC_POLL_CMD_EN
        if (poll_armed_q && !a0) begin
            rd_mux    = '0;
            rd_mux[7] = |(irr_in[7:0] & ~imr_q[7:0]);
            rd_mux[2:0] = lowest_set(irr_in[7:0] & ~imr_q[7:0]);
        end
`endif
        d_out = d_oe ? rd_mux : '0;
    end

    assign ltim     = ltim_q;
    assign sngl     = sngl_q;
    assign ic4      = ic4_q;
    assign vec_base = vec_base_q;
    assign icw3     = icw3_q;
    assign icw4     = icw4_q;
    assign imr      = imr_q;
    assign ocw2_vld = ocw2_vld_q;
    assign ocw2_cmd = ocw2_cmd_q;
    assign ocw2_lvl = ocw2_lvl_q;
    assign ris      = ris_q;
    assign smm      = smm_q;
`ifdef PIC_POLL_CMD_EN
    assign poll_ack = poll_ack_q;
`endif

endmodule

// File: tb/tb_pic_bus_ctrl.sv
// tb/tb_pic_bus_ctrl.sv - scoreboard bench for pic_bus_ctrl with directed and random bus cycles
`timescale 1ns/1ps
module tb_pic_bus_ctrl;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
    logic [DW-1:0] d_in = '0, irr_in = '0, isr_in = '0;
    logic [DW-1:0] d_out, icw3, imr;
    logic          d_oe, init_done, ltim, sngl, ic4, ocw2_vld, ris, smm;
    logic [4:0]    vec_base, icw4;
    logic [2:0]    ocw2_cmd, ocw2_lvl;

    always #5 clk = ~clk;

    pic_bus_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .irr_in(irr_in), .isr_in(isr_in),
        .init_done(init_done), .vec_base(vec_base), .ltim(ltim), .sngl(sngl), .ic4(ic4),
        .icw3(icw3), .icw4(icw4), .imr(imr), .ocw2_vld(ocw2_vld), .ocw2_cmd(ocw2_cmd),
        .ocw2_lvl(ocw2_lvl), .ris(ris), .smm(smm)
    );

    typedef struct {
        logic          init_done;
        logic [4:0]    vec_base;
        logic          ltim, sngl, ic4;
        logic [DW-1:0] icw3;
        logic [4:0]    icw4;
        logic [DW-1:0] imr;
        logic [2:0]    cmd, lvl;
        logic          ris, smm;
    } snap_t;

    // Reference model: programming step reached (1..4 = awaiting ICW1..ICW4, 5 = ready).
    int    m_step;
    snap_t m;

    snap_t         snap_q[$];
    string         tag_q[$];
    logic [DW-1:0] read_q[$];
    logic [5:0]    ocw2_q[$];

    int passed = 0;
    int total  = 0;
    logic prev_oe = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void model_reset();
        m_step = 1;
        m = '{init_done: 1'b0, vec_base: '0, ltim: 1'b0, sngl: 1'b0, ic4: 1'b0,
              icw3: '0, icw4: '0, imr: '0, cmd: '0, lvl: '0, ris: 1'b0, smm: 1'b0};
    endfunction

    function automatic void model_write(logic a, logic [DW-1:0] d, logic c);
        if (c) return;
        if (!a && d[4]) begin
            m.ltim = d[3]; m.sngl = d[1]; m.ic4 = d[0];
            m.imr = '0; m.icw3 = '0; m.icw4 = '0; m.ris = 1'b0; m.smm = 1'b0;
            m_step = 2;
        end else if (m_step == 2 && a) begin
            m.vec_base = d[7:3];
            m_step = (m.sngl == 1'b0) ? 3 : (m.ic4 ? 4 : 5);
        end else if (m_step == 3 && a) begin
            m.icw3 = d;
            m_step = m.ic4 ? 4 : 5;
        end else if (m_step == 4 && a) begin
            m.icw4 = d[4:0];
            m_step = 5;
        end else if (m_step == 5) begin
            if (a) m.imr = d;
            else if (!d[3]) begin
                m.cmd = d[7:5]; m.lvl = d[2:0];
                ocw2_q.push_back({d[7:5], d[2:0]});
            end else begin
                if (d[1]) m.ris = d[0];
                if (d[6]) m.smm = d[5];
            end
        end
        m.init_done = (m_step == 5);
    endfunction

    function automatic logic [DW-1:0] model_read(logic a);
        if (a) return m.imr;
        return m.ris ? isr_in : irr_in;
    endfunction

    task automatic push_snap(string tag);
        snap_q.push_back(m);
        tag_q.push_back(tag);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        snap_t e;
        string t;
        logic [5:0] oe;
        if (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".init_done"}, init_done, e.init_done);
            chk({t, ".vec_base"}, vec_base, e.vec_base);
            chk({t, ".icw1"}, {ltim, sngl, ic4}, {e.ltim, e.sngl, e.ic4});
            chk({t, ".icw3"}, icw3, e.icw3);
            chk({t, ".icw4"}, icw4, e.icw4);
            chk({t, ".imr"}, imr, e.imr);
            chk({t, ".ocw2"}, {ocw2_cmd, ocw2_lvl}, {e.cmd, e.lvl});
            chk({t, ".ris_smm"}, {ris, smm}, {e.ris, e.smm});
        end
        if (ocw2_vld) begin
            if (ocw2_q.size() > 0) begin
                oe = ocw2_q.pop_front();
                chk("ocw2_pulse", {ocw2_cmd, ocw2_lvl}, oe);
            end else begin
                chk("ocw2_vld_unexpected", 1, 0);
            end
        end
        if (d_oe && !prev_oe) begin
            if (read_q.size() > 0) chk("read_data", d_out, read_q.pop_front());
            else chk("d_oe_unexpected", 1, 0);
        end
        if (!d_oe && d_out != '0) chk("d_out_idle_zero", d_out, 0);
        prev_oe <= d_oe;
    end

    task automatic bus_write(input logic a, input logic [DW-1:0] d, input logic c,
                             input logic with_rd = 1'b0);
        @(posedge clk); #1;
        cs_n = c; a0 = a; d_in = d; wr_n = 1'b0;
        if (with_rd) rd_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        wr_n = 1'b1; rd_n = 1'b1;
        repeat (SS) @(posedge clk); #1;
        push_snap("pre_commit");
        model_write(a, d, c);
        @(posedge clk); #1;
        push_snap("post_commit");
        repeat (2) @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic bus_read(input logic a, input logic c);
        @(posedge clk); #1;
        cs_n = c; a0 = a; rd_n = 1'b0;
        if (!c) read_q.push_back(model_read(a));
        repeat (SS + 2) @(posedge clk); #1;
        rd_n = 1'b1;
        repeat (SS + 1) @(posedge clk); #1;
        cs_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; cs_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        push_snap("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] rd;
        int r;
        model_reset();
        repeat (2) @(posedge clk); #1;
        push_snap("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        bus_write(1'b0, 8'h13, 1'b0);
        bus_write(1'b1, 8'h48, 1'b0);
        bus_write(1'b1, 8'h01, 1'b0);

        bus_write(1'b0, 8'h11, 1'b0);
        bus_write(1'b1, 8'h20, 1'b0);
        bus_write(1'b1, 8'h04, 1'b0);
        bus_write(1'b1, 8'h1D, 1'b0);

        bus_write(1'b1, 8'hA5, 1'b0);
        bus_read(1'b1, 1'b0);
        bus_write(1'b0, 8'h0B, 1'b0);
        @(posedge clk); #1;
        irr_in = 8'h0F; isr_in = 8'h02;
        bus_read(1'b0, 1'b0);

        bus_write(1'b0, 8'h20, 1'b0);
        bus_write(1'b1, 8'hFF, 1'b1);
        bus_read(1'b0, 1'b1);

        bus_write(1'b0, 8'h13, 1'b0);
        bus_write(1'b1, 8'h48, 1'b0);
        bus_write(1'b0, 8'h11, 1'b0);
        bus_write(1'b1, 8'h20, 1'b0);

        // Reset lands while the ICW3 strobe is still low.
        @(posedge clk); #1;
        cs_n = 1'b0; a0 = 1'b1; d_in = 8'h04; wr_n = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        bus_write(1'b1, 8'h55, 1'b0);
        bus_write(1'b0, 8'h13, 1'b0);
        bus_write(1'b1, 8'h48, 1'b0);
        bus_write(1'b1, 8'h01, 1'b0);

        bus_write(1'b1, 8'h3C, 1'b0, 1'b1);
        bus_read(1'b1, 1'b0);

        for (int i = 0; i < 90; i++) begin
            r  = $urandom_range(0, 9);
            rd = DW'($urandom);
            case (r)
                0:       bus_write(1'b0, rd | 8'h10, 1'b0);
                1, 2, 3: bus_write(1'b1, rd, 1'b0, 1'($urandom_range(0, 3) == 0));
                4, 5, 6: bus_write(1'b0, rd & 8'hEF, 1'b0);
                7:       bus_write(1'($urandom), rd, 1'b1);
                default: begin
                    @(posedge clk); #1;
                    irr_in = DW'($urandom); isr_in = DW'($urandom);
                    bus_read(1'($urandom), 1'($urandom_range(0, 4) == 0));
                end
            endcase
        end

        repeat (4) @(posedge clk); #1;
        chk("read_queue_drained", read_q.size(), 0);
        chk("ocw2_queue_drained", ocw2_q.size(), 0);
        chk("snap_queue_drained", snap_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pic_bus_ctrl.md
Name: pic_bus_ctrl

Overview:
- Synchronous, parametrised CPU-side bus interface and command-word register file for the PIC.
- Replaces the unclocked read/write logic and tri-state buffer with:
  - synchronised strobes
  - an explicit ICW1..ICW4 initialisation sequencer
  - OCW1..OCW3 decode
  - a split data bus: d_in, d_out, d_oe
- Sits between the CPU bus pins and the priority resolver / IRR / ISR logic.

Parameters:
- DATA_W, 8, data bus and IRQ vector width (>=8); ICW/OCW fields use the low 8 bits, IMR/ICW3/read paths use all DATA_W.
- SYNC_STAGES, 2, flip-flops in each wr_n/rd_n synchroniser (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low, asynchronous to clk
- rd_n  in  1  read strobe, active low, asynchronous to clk
- a0  in  1  address bit
- d_in  in  DATA_W  CPU write data
- d_out  out  DATA_W  CPU read data
- d_oe  out  1  drive enable for pad buffer
- irr_in  in  DATA_W  interrupt request register snapshot
- isr_in  in  DATA_W  in-service register snapshot
- init_done  out  1  initialisation sequence complete
- vec_base  out  5  ICW2[7:3]
- ltim, sngl, ic4  out  1 each  ICW1 D3, D1, D0
- icw3  out  DATA_W  cascade configuration
- icw4  out  5  ICW4[4:0] (SFNM, BUF, M/S, AEOI, uPM)
- imr  out  DATA_W  interrupt mask (OCW1)
- ocw2_vld  out  1  one-cycle pulse on OCW2 write
- ocw2_cmd  out  3  OCW2 R, SL, EOI
- ocw2_lvl  out  3  OCW2 L2:L0
- ris  out  1  read-select: 0 = IRR, 1 = ISR
- smm  out  1  special mask mode

Behaviour:
- Each of wr_n and rd_n passes through a SYNC_STAGES synchroniser. Falling and rising edges are detected on the synchronised value.
- cs_n, a0 and d_in are registered every cycle while synchronised wr_n is low.
- A write commits on the synchronised wr_n rising edge, using the last registered values, and only if the registered cs_n was 0.
- Commit latency: outputs update 1 clk after the detected rising edge.
- FSM states: S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_READY. Reset enters S_ICW1.
- ICW1 detection (a0=0 and D4=1), from any state:
  - latch ltim, sngl, ic4
  - clear imr, icw3 and icw4; ris=0; smm=0
  - init_done=0; go to S_ICW2
- In S_ICW1, any write other than ICW1 is ignored.
- S_ICW2, a0=1: vec_base=D7:3. Next state: S_ICW3 if sngl=0; else S_ICW4 if ic4=1; else S_READY.
- S_ICW3, a0=1: icw3=d_in. Next state: S_ICW4 if ic4=1, else S_READY.
- S_ICW4, a0=1: icw4=D4:0, then go to S_READY.
- a0=0 writes during S_ICW2..S_ICW4 are ignored unless they are ICW1.
- init_done=1 exactly while in S_READY.
- In S_READY:
  - a0=1: imr=d_in (OCW1).
  - a0=0, D4=0, D3=0 (OCW2): ocw2_cmd=D7:5, ocw2_lvl=D2:0, ocw2_vld pulses for 1 clk.
  - a0=0, D4=0, D3=1 (OCW3):
    - if D1=1, ris=D0
    - if D6=1, smm=D5
    - otherwise each field is unchanged.
- Read path:
  - d_oe=1 while synchronised rd_n is low and cs_n=0.
  - d_out = imr if a0=1; otherwise isr_in if ris=1, else irr_in.
  - d_out is 0 when d_oe=0.
- Simultaneous read and write: if synchronised wr_n and rd_n are both low, d_oe is forced to 0 and the write still commits.
- Reset values: all outputs 0; state S_ICW1.
- Reset asserted mid-sequence aborts it; a full ICW1 restart is required afterwards.

Optional Feature:
- Macro PIC_POLL_CMD_EN.
- With the macro: OCW3 D2=1 arms poll mode. The next read with a0=0 returns the poll word instead of IRR/ISR:
  - bit7 = |(irr_in & ~imr)
  - bits2:0 = lowest-numbered set bit of (irr_in & ~imr), IRQ0 highest priority
  - other bits 0
- Poll mode disarms on that read's rd_n rising edge. The extra port poll_ack (out, 1) pulses at disarm for the ISR logic.
- Without the macro: D2 is ignored, and neither poll_ack nor the poll logic exists.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum (S_ICW1..S_READY)
  - ICW1/OCW bit-position constants
  - OCW2 command encodings (non-specific EOI 3'b001, specific EOI 3'b011, rotate-on-AEOI 3'b100, ...)
- One sub-module, pic_strobe_sync: SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated for wr_n and rd_n.

Test Plan:
- Reset, then write ICW1=8'h13 (sngl=1, ic4=1), ICW2=8'h48, ICW4=8'h01 → vec_base=5'h09, icw3=0, icw4=5'h01, init_done=1 one clk after the third strobe.
- ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h1D → icw3=8'h04, icw4=5'h1D; init_done stays low until the ICW4 commit.
- In S_READY: OCW1=8'hA5, then read with a0=1 → d_oe=1, d_out=8'hA5. OCW3=8'h0B, irr_in=8'h0F, isr_in=8'h02, read with a0=0 → d_out=8'h02.
- OCW2=8'h20 → one-cycle ocw2_vld, ocw2_cmd=3'b001, ocw2_lvl=0. A write with cs_n=1 produces no change.
- Mid-init ICW1 after ICW2 restarts the sequence and clears imr. rst_n pulsed low mid-ICW3 → all outputs 0, state S_ICW1. rd_n and wr_n low together → d_oe stays 0 and the write commits.
